// File: rtl/alu_sequencer.sv
// alu_sequencer
// -------------
// Small instruction sequencer that owns a 4-entry register file and drives an
// external combinational ALU. Each instruction takes three states:
//   IDLE (accept) -> EXEC (operands out, result back same cycle) -> DONE (hold result)
// A direct register load is accepted only in IDLE and wins over an instruction
// offered in the same cycle.
//
// Optional feature: define SEQ_FLAGS_EN to get registered zero/carry flags that
// update at every EXEC writeback. Without it both flags are tied to 0.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   instr_valid/ready      instruction handshake; instr = {op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}
//   ld_valid/addr/data     direct register-file write (IDLE only)
//   alu_a/alu_b/alu_sel    operands and opcode to the external ALU (0 outside EXEC)
//   alu_out/alu_carry      result returned by the external ALU in the same cycle
//   res_valid/ready        result handshake; res_data/res_carry held while in DONE
//   busy                   high whenever the FSM is not in IDLE
//   zero_flag/carry_flag   status of the last writeback (SEQ_FLAGS_EN only)
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [8:0]       instr,
    input  logic             ld_valid,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             busy,
    output logic             zero_flag,
    output logic             carry_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] regs [4];
    logic [2:0]       op_q;
    logic [1:0]       rd_q;
    logic [1:0]       rs1_q;
    logic [1:0]       rs2_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_carry_q;
    logic             instr_accept;

    // A pending load blocks instruction acceptance so the two never collide
    // on the register file in the same edge.
    assign instr_ready  = (state_q == IDLE) && !ld_valid;
    assign instr_accept = instr_ready && instr_valid;
    assign busy         = (state_q != IDLE);
    assign res_valid    = (state_q == DONE);
    assign res_data     = res_data_q;
    assign res_carry    = res_carry_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fixed IDLE -> EXEC -> DONE -> IDLE ring; the spare
    // encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU drive. The register file cannot change during EXEC (loads are IDLE
    // only, writeback lands on the EXEC->DONE edge), so a combinational read
    // gives the operand values as of the start of EXEC, even when rd aliases
    // rs1 or rs2.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 3'b000;
        if (state_q == EXEC) begin
            alu_a   = regs[rs1_q];
            alu_b   = regs[rs2_q];
            alu_sel = op_q;
        end
    end

    // Register file, latched instruction fields and result holding register.
    // Reset clears everything, which also discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            if (state_q == IDLE && ld_valid) begin
                regs[ld_addr] <= ld_data;
            end
            if (instr_accept) begin
                op_q  <= instr[8:6];
                rd_q  <= instr[5:4];
                rs1_q <= instr[3:2];
                rs2_q <= instr[1:0];
            end
            if (state_q == EXEC) begin
                regs[rd_q]  <= alu_out;
                res_data_q  <= alu_out;
                res_carry_q <= alu_carry;
            end
        end
    end

`ifdef SEQ_FLAGS_EN
    logic zero_q;
    logic carry_q;

    // Status flags follow the last writeback and hold between instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (state_q == EXEC) begin
            zero_q  <= (alu_out == '0);
            carry_q <= alu_carry;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`else
    assign zero_flag  = 1'b0;
    assign carry_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. Models the external ALU combinationally,
// drives directed vectors with hand-computed results, and scores every result
// handshake against a queue of expected {carry, data} values.
module tb_alu_sequencer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [8:0]       instr;
    logic             ld_valid;
    logic [1:0]       ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             busy;
    logic             zero_flag;
    logic             carry_flag;

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] exp_q [$];

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .busy        (busy),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: 000 ADD, 001 SUB (carry = borrow), 010 AND, 011 OR, 100 XOR, else pass A.
    always_comb begin
        alu_out   = alu_a;
        alu_carry = 1'b0;
        case (alu_sel)
            3'b000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Flags are only live with SEQ_FLAGS_EN; otherwise they must read 0.
    task automatic check_flags(input logic z, input logic c);
`ifdef SEQ_FLAGS_EN
        checkOutput("zero_flag", zero_flag, z);
        checkOutput("carry_flag", carry_flag, c);
`else
        checkOutput("zero_flag_off", zero_flag, 1'b0);
        checkOutput("carry_flag_off", carry_flag, 1'b0);
`endif
    endtask

    // Scoreboard monitor: pops one expectation per completed result handshake.
    always @(negedge clk) begin
        logic [WIDTH:0] exp;
        #2;
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got %0h, expected none at %0t", res_data, $time);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("res_data", res_data, exp[WIDTH-1:0]);
                checkOutput("res_carry", res_carry, exp[WIDTH]);
            end
        end
    end

    task automatic load_reg(input logic [1:0] addr, input logic [WIDTH-1:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
    endtask

    // Issues one instruction and walks it through EXEC and DONE. With hold>0,
    // res_ready stays low for that many DONE cycles while a load to rd is attempted.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [WIDTH-1:0] exp_a,
                                 input logic [WIDTH-1:0] exp_b, input logic [WIDTH-1:0] exp_data,
                                 input logic exp_carry, input int hold);
        instr_valid = 1'b1;
        instr       = {op, rd, rs1, rs2};
        res_ready   = (hold == 0);
        #1;
        checkOutput("instr_ready_idle", instr_ready, 1'b1);
        exp_q.push_back({exp_carry, exp_data});
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        #1;
        checkOutput("busy_exec", busy, 1'b1);
        checkOutput("alu_a", alu_a, exp_a);
        checkOutput("alu_b", alu_b, exp_b);
        checkOutput("alu_sel", alu_sel, op);
        checkOutput("res_valid_exec", res_valid, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("res_valid_latency", res_valid, 1'b1);
        checkOutput("alu_a_done", alu_a, '0);
        for (int i = 0; i < hold; i++) begin
            ld_valid = 1'b1;
            ld_addr  = rd;
            ld_data  = 8'h77;
            #1;
            checkOutput("hold_res_valid", res_valid, 1'b1);
            checkOutput("hold_res_data", res_data, exp_data);
            checkOutput("hold_instr_ready", instr_ready, 1'b0);
            @(negedge clk);
        end
        ld_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("busy_idle", busy, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        res_ready   = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_res_valid", res_valid, 1'b0);
        checkOutput("rst_res_data", res_data, '0);
        checkOutput("rst_res_carry", res_carry, 1'b0);
        checkOutput("rst_alu_a", alu_a, '0);
        checkOutput("rst_alu_b", alu_b, '0);
        checkOutput("rst_alu_sel", alu_sel, 3'b000);
        checkOutput("rst_zero_flag", zero_flag, 1'b0);
        checkOutput("rst_carry_flag", carry_flag, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // r1=0F, r2=01, ADD r3 = r1 + r2 -> 10; then read r3 back through OR.
        load_reg(2'd1, 8'h0F);
        load_reg(2'd2, 8'h01);
        applyStimulus(3'b000, 2'd3, 2'd1, 2'd2, 8'h0F, 8'h01, 8'h10, 1'b0, 0);
        check_flags(1'b0, 1'b0);
        applyStimulus(3'b011, 2'd0, 2'd3, 2'd3, 8'h10, 8'h10, 8'h10, 1'b0, 0);

        // r1=FF, ADD r1 = r1 + r1 -> FE carry 1; read r1 back with XOR against r0=10.
        load_reg(2'd1, 8'hFF);
        applyStimulus(3'b000, 2'd1, 2'd1, 2'd1, 8'hFF, 8'hFF, 8'hFE, 1'b1, 0);
        check_flags(1'b0, 1'b1);
        applyStimulus(3'b100, 2'd2, 2'd1, 2'd0, 8'hFE, 8'h10, 8'hEE, 1'b0, 0);

        // SUB r0 = r2 - r2 -> 0 sets the zero flag.
        applyStimulus(3'b001, 2'd0, 2'd2, 2'd2, 8'hEE, 8'hEE, 8'h00, 1'b0, 0);
        check_flags(1'b1, 1'b0);

        // Load and instruction offered together: load first, instruction next cycle.
        ld_valid    = 1'b1;
        ld_addr     = 2'd3;
        ld_data     = 8'h5A;
        instr_valid = 1'b1;
        instr       = {3'b000, 2'd0, 2'd3, 2'd3};
        res_ready   = 1'b1;
        #1;
        checkOutput("collide_instr_ready", instr_ready, 1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checkOutput("collide_still_idle", busy, 1'b0);
        checkOutput("collide_instr_ready_next", instr_ready, 1'b1);
        exp_q.push_back({1'b0, 8'hB4});
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checkOutput("collide_busy", busy, 1'b1);
        checkOutput("collide_alu_a", alu_a, 8'h5A);
        checkOutput("collide_alu_b", alu_b, 8'h5A);
        @(negedge clk);
        #1;
        checkOutput("collide_res_valid", res_valid, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("collide_idle", busy, 1'b0);

        // AND r1 = r3 & r0 = 5A & B4 -> 10, result held 5 cycles with a load to r1 attempted.
        applyStimulus(3'b010, 2'd1, 2'd3, 2'd0, 8'h5A, 8'hB4, 8'h10, 1'b0, 5);
        applyStimulus(3'b011, 2'd2, 2'd1, 2'd1, 8'h10, 8'h10, 8'h10, 1'b0, 0);

        // Reset during EXEC of XOR r3 = r1 ^ r2: abort, no result, registers cleared.
        instr_valid = 1'b1;
        instr       = {3'b100, 2'd3, 2'd1, 2'd2};
        exp_q.push_back({1'b0, 8'h00});
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        checkOutput("pre_reset_alu_sel", alu_sel, 3'b100);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("mid_reset_alu_a", alu_a, '0);
        checkOutput("mid_reset_alu_b", alu_b, '0);
        checkOutput("mid_reset_alu_sel", alu_sel, 3'b000);
        checkOutput("mid_reset_busy", busy, 1'b0);
        checkOutput("mid_reset_res_valid", res_valid, 1'b0);
        checkOutput("mid_reset_res_data", res_data, '0);
        check_flags(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_reset_busy", busy, 1'b0);
        checkOutput("post_reset_instr_ready", instr_ready, 1'b1);
        checkOutput("post_reset_res_valid", res_valid, 1'b0);
        load_reg(2'd1, 8'h33);
        applyStimulus(3'b011, 2'd0, 2'd3, 2'd1, 8'h00, 8'h33, 8'h33, 1'b0, 0);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
